// File: rtl/gain_sched_if.sv
// Request/response stream bundle for gain_sched.
//   req_v    : per-channel sample valid          (toward scheduler)
//   req_data : channel k sample in [k*DIN_WIDTH +: DIN_WIDTH]
//   req_rdy  : per-channel accept, one-hot or zero (from scheduler)
//   out_data : scaled sample                     (from scheduler)
//   out_ch   : channel of out_data               (from scheduler)
//   out_v    : output valid                      (from scheduler)
//   out_rdy  : downstream accept                 (toward scheduler)
// master: the surrounding system (sources requests, sinks results); slave: gain_sched.
interface gain_sched_if #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned DIN_WIDTH = 16
);
  localparam int unsigned ChW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]           req_v;
  logic [NUM_CH*DIN_WIDTH-1:0] req_data;
  logic [NUM_CH-1:0]           req_rdy;
  logic [DIN_WIDTH-1:0]        out_data;
  logic [ChW-1:0]              out_ch;
  logic                        out_v;
  logic                        out_rdy;

  modport master (
    output req_v, req_data, out_rdy,
    input  req_rdy, out_data, out_ch, out_v
  );

  modport slave (
    input  req_v, req_data, out_rdy,
    output req_rdy, out_data, out_ch, out_v
  );
endinterface

// File: rtl/gain_sched.sv
// Round-robin scheduler sharing one external gain stage among NUM_CH channels.
// Accepted samples are sent to the gain stage with the channel's gain, results are
// tagged with their channel and queued in a small output FIFO. A credit scheme keeps
// in-flight plus queued results within FIFO_DEPTH so the FIFO never overflows.
//   clk, rst_n           : clock, asynchronous active-low reset
//   cfg_we/cfg_ch/cfg_gain : gain-table write port (gain unsigned Q2.14)
//   bus (slave)          : request and output streams, see gain_sched_if
//   gs_din/gs_gain/gs_din_v : registered sample/gain to the gain stage
//   gs_dout/gs_dout_v    : gain-stage result, GS_LATENCY cycles after gs_din_v
//   ovf                  : sticky, a result arrived while the FIFO was full
module gain_sched #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DIN_WIDTH  = 16,
  parameter int unsigned GAIN_WIDTH = 16,
  parameter int unsigned GS_LATENCY = 3,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned ChW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_we,
  input  logic [ChW-1:0]        cfg_ch,
  input  logic [GAIN_WIDTH-1:0] cfg_gain,
  gain_sched_if.slave           bus,
  output logic [DIN_WIDTH-1:0]  gs_din,
  output logic [GAIN_WIDTH-1:0] gs_gain,
  output logic                  gs_din_v,
  input  logic [DIN_WIDTH-1:0]  gs_dout,
  input  logic                  gs_dout_v,
  output logic                  ovf
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BlkW = $clog2(GS_LATENCY + 1);
  localparam logic [GAIN_WIDTH-1:0] GainOne = {2'b01, {(GAIN_WIDTH - 2){1'b0}}};

  // State
  logic [GAIN_WIDTH-1:0] gain_q [NUM_CH];
  logic [GAIN_WIDTH-1:0] gain_d [NUM_CH];
  logic [ChW-1:0]        last_grant_q, last_grant_d;
  logic [CntW-1:0]       inflight_q, inflight_d;
  logic [DIN_WIDTH-1:0]  gs_din_q, gs_din_d;
  logic [GAIN_WIDTH-1:0] gs_gain_q, gs_gain_d;
  logic                  gs_din_v_q, gs_din_v_d;
  logic [ChW-1:0]        gs_tag_q, gs_tag_d;
  logic [ChW-1:0]        tag_q [GS_LATENCY];
  logic [ChW-1:0]        tag_d [GS_LATENCY];
  logic [BlkW-1:0]       blank_q, blank_d;
  logic [DIN_WIDTH-1:0]  mem_data_q [FIFO_DEPTH];
  logic [ChW-1:0]        mem_tag_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;

  // Combinational
  logic                  credit;
  logic [NUM_CH-1:0]     grant;
  logic [ChW-1:0]        grant_idx;
  logic [ChW-1:0]        cand;
  logic                  grant_any;
  logic                  dout_ok;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  dec;

  assign credit = (32'(inflight_q) + 32'(cnt_q)) < FIFO_DEPTH;

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    grant     = '0;
    grant_idx = last_grant_q;
    grant_any = 1'b0;
    cand      = '0;
    if (rst_n && credit) begin
      for (int unsigned i = 1; i <= NUM_CH; i++) begin
        cand = ChW'((32'(last_grant_q) + i) % NUM_CH);
        if (!grant_any && bus.req_v[cand]) begin
          grant[cand] = 1'b1;
          grant_idx   = cand;
          grant_any   = 1'b1;
        end
      end
    end
  end

  // Gain table: a write in the accept cycle only affects later accepts.
  always_comb begin
    gain_d = gain_q;
    if (cfg_we && (32'(cfg_ch) < NUM_CH)) begin
      gain_d[cfg_ch] = cfg_gain;
    end
  end

  always_comb begin
    last_grant_d = grant_any ? grant_idx : last_grant_q;
    gs_din_d     = gs_din_q;
    gs_gain_d    = gs_gain_q;
    gs_tag_d     = gs_tag_q;
    gs_din_v_d   = grant_any;
    if (grant_any) begin
      gs_din_d  = bus.req_data[32'(grant_idx) * DIN_WIDTH +: DIN_WIDTH];
      gs_gain_d = gain_q[grant_idx];
      gs_tag_d  = grant_idx;
    end
  end

  // Channel tags travel alongside the gain stage so they line up with gs_dout_v.
  always_comb begin
    tag_d[0] = gs_tag_q;
    for (int unsigned i = 1; i < GS_LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // Results during the first GS_LATENCY cycles after reset belong to discarded work.
  always_comb begin
    blank_d = (blank_q != '0) ? blank_q - BlkW'(1) : blank_q;
  end

  assign dout_ok = gs_dout_v && (blank_q == '0);
  assign full    = (cnt_q == CntW'(FIFO_DEPTH));
  assign push    = dout_ok && !full;
  assign pop     = (cnt_q != '0) && bus.out_rdy;
  // Guard against a spurious result underflowing the in-flight count.
  assign dec     = dout_ok && (inflight_q != '0);

  always_comb begin
    inflight_d = inflight_q + CntW'(grant_any) - CntW'(dec);
    cnt_d      = cnt_q + CntW'(push) - CntW'(pop);
    ovf_d      = ovf_q | (dout_ok && full);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        gain_q[i] <= GainOne;
      end
      for (int unsigned i = 0; i < GS_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
      last_grant_q <= ChW'(NUM_CH - 1);
      inflight_q   <= '0;
      gs_din_q     <= '0;
      gs_gain_q    <= '0;
      gs_din_v_q   <= 1'b0;
      gs_tag_q     <= '0;
      blank_q      <= BlkW'(GS_LATENCY);
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
    end else begin
      gain_q       <= gain_d;
      tag_q        <= tag_d;
      last_grant_q <= last_grant_d;
      inflight_q   <= inflight_d;
      gs_din_q     <= gs_din_d;
      gs_gain_q    <= gs_gain_d;
      gs_din_v_q   <= gs_din_v_d;
      gs_tag_q     <= gs_tag_d;
      blank_q      <= blank_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
    end
  end

  // FIFO storage needs no reset; the output is masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= gs_dout;
      mem_tag_q[wr_ptr_q]  <= tag_q[GS_LATENCY-1];
    end
  end

  assign bus.req_rdy  = grant;
  assign bus.out_v    = (cnt_q != '0);
  assign bus.out_data = (cnt_q != '0) ? mem_data_q[rd_ptr_q] : '0;
  assign bus.out_ch   = (cnt_q != '0) ? mem_tag_q[rd_ptr_q] : '0;
  assign gs_din       = gs_din_q;
  assign gs_gain      = gs_gain_q;
  assign gs_din_v     = gs_din_v_q;
  assign ovf          = ovf_q;

endmodule

// File: tb/tb_gain_sched.sv
module tb_gain_sched;
  localparam int NUM_CH = 4;
  localparam int DW     = 16;
  localparam int GW     = 16;
  localparam int LAT    = 3;
  localparam int DEPTH  = 4;
  localparam int CHW    = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           cfg_we;
  logic [CHW-1:0] cfg_ch;
  logic [GW-1:0]  cfg_gain;
  logic [DW-1:0]  gs_din;
  logic [GW-1:0]  gs_gain;
  logic           gs_din_v;
  logic [DW-1:0]  gs_dout;
  logic           gs_dout_v;
  logic           ovf;

  gain_sched_if #(.NUM_CH(NUM_CH), .DIN_WIDTH(DW)) bus ();

  gain_sched #(
    .NUM_CH(NUM_CH), .DIN_WIDTH(DW), .GAIN_WIDTH(GW), .GS_LATENCY(LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_gain(cfg_gain),
    .bus(bus), .gs_din(gs_din), .gs_gain(gs_gain), .gs_din_v(gs_din_v),
    .gs_dout(gs_dout), .gs_dout_v(gs_dout_v), .ovf(ovf)
  );

  // Unsigned Q2.14 multiply, truncated to the sample width.
  function automatic logic [DW-1:0] scale(input logic [DW-1:0] d, input logic [GW-1:0] g);
    logic [63:0] p;
    p = 64'(d) * 64'(g);
    return p[14 +: DW];
  endfunction

  // Gain stage model: fixed LAT-cycle pipeline, with an injection port for overflow tests.
  logic [DW-1:0] pipe_d [LAT];
  logic          pipe_v [LAT];
  logic          force_v;
  logic [DW-1:0] force_d;
  initial for (int i = 0; i < LAT; i++) begin pipe_v[i] = 1'b0; pipe_d[i] = '0; end
  always @(posedge clk) begin
    pipe_v[0] <= gs_din_v;
    pipe_d[0] <= scale(gs_din, gs_gain);
    for (int i = 1; i < LAT; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_d[i] <= pipe_d[i-1];
    end
  end
  assign gs_dout_v = pipe_v[LAT-1] | force_v;
  assign gs_dout   = force_v ? force_d : pipe_d[LAT-1];

  // Reference model and scoreboard
  typedef struct {
    int            ch;
    logic [DW-1:0] data;
    longint        cyc;
    bit            chk_lat;
  } exp_t;

  exp_t          q[$];
  logic [GW-1:0] m_gain [NUM_CH];
  int            m_last;
  int            acc_cnt;
  int            pop_cnt;
  longint        cyc = 0;
  bit            chk_en;
  bit            lat_mark;
  int            n_tests = 0;
  int            n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    for (int i = 0; i < NUM_CH; i++) m_gain[i] = 16'h4000;
    m_last  = NUM_CH - 1;
    acc_cnt = 0;
    pop_cnt = 0;
  endfunction

  // Monitor: grant prediction, accept capture, gain-table tracking, output compare.
  always @(negedge clk) begin : mon
    logic [NUM_CH-1:0] exp_rdy;
    int                k;
    exp_t              e;
    if (chk_en) begin
      exp_rdy = '0;
      // Results outstanding anywhere in the datapath = accepted minus delivered.
      if ((acc_cnt - pop_cnt) < DEPTH && bus.req_v != '0) begin
        for (int i = 1; i <= NUM_CH; i++) begin
          k = (m_last + i) % NUM_CH;
          if (exp_rdy == '0 && bus.req_v[k]) exp_rdy[k] = 1'b1;
        end
      end
      check("req_rdy", 64'(bus.req_rdy), 64'(exp_rdy));
      for (int c = 0; c < NUM_CH; c++) begin
        if (bus.req_v[c] && bus.req_rdy[c]) begin
          e.ch      = c;
          e.data    = scale(bus.req_data[c*DW +: DW], m_gain[c]);
          e.cyc     = cyc;
          e.chk_lat = lat_mark;
          q.push_back(e);
          acc_cnt++;
          m_last = c;
        end
      end
      if (cfg_we) m_gain[cfg_ch] = cfg_gain;
      if (bus.out_v && bus.out_rdy) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out: got ch %0d data 0x%0h, expected no output",
                   bus.out_ch, bus.out_data);
        end else begin
          e = q.pop_front();
          check("out_ch", 64'(bus.out_ch), 64'(e.ch));
          check("out_data", 64'(bus.out_data), 64'(e.data));
          if (e.chk_lat) check("latency", 64'(cyc - e.cyc), 64'(LAT + 2));
        end
        pop_cnt++;
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int a0;
    int t;
    bit seen;
    chk_en = 1'b0; lat_mark = 1'b0; force_v = 1'b0; force_d = '0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_gain = '0;
    bus.req_v = '1; bus.req_data = {$urandom, $urandom}; bus.out_rdy = 1'b1;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req_rdy", 64'(bus.req_rdy), 0);
    check("rst_gs_din_v", 64'(gs_din_v), 0);
    check("rst_gs_din", 64'(gs_din), 0);
    check("rst_gs_gain", 64'(gs_gain), 0);
    check("rst_out_v", 64'(bus.out_v), 0);
    check("rst_out_data", 64'(bus.out_data), 0);
    check("rst_out_ch", 64'(bus.out_ch), 0);
    check("rst_ovf", 64'(ovf), 0);
    @(posedge clk); #1;
    bus.req_v = '0; rst_n = 1'b1; chk_en = 1'b1;
    step(2);

    // Single ch0 sample with default gain, latency checked
    bus.req_data[0 +: DW] = 16'h1234; bus.req_v = 4'b0001; lat_mark = 1'b1;
    step();
    bus.req_v = '0; lat_mark = 1'b0;
    step(10);

    // All channels requesting: round-robin order
    bus.req_v = 4'hF;
    repeat (20) begin bus.req_data = {$urandom, $urandom}; step(); end
    bus.req_v = '0;
    step(10);

    // Gain write in ch2's accept cycle: old gain first, new gain next
    bus.req_data[2*DW +: DW] = 16'h0100; bus.req_v = 4'b0100;
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_gain = 16'h8000;
    step();
    bus.req_v = '0; cfg_we = 1'b0;
    step(2);
    bus.req_v = 4'b0100;
    step();
    bus.req_v = '0;
    step(10);

    // Back-pressure: credit stops accepts at FIFO_DEPTH
    bus.out_rdy = 1'b0; a0 = acc_cnt; bus.req_v = 4'hF;
    repeat (12) begin bus.req_data = {$urandom, $urandom}; step(); end
    check("accepts_blocked", 64'(acc_cnt - a0), 64'(DEPTH));
    check("rdy_blocked", 64'(bus.req_rdy), 0);
    bus.out_rdy = 1'b1;
    repeat (8) begin bus.req_data = {$urandom, $urandom}; step(); end
    bus.req_v = '0;
    step(12);

    // Overflow: inject a result while the FIFO is full
    bus.out_rdy = 1'b0; bus.req_v = 4'hF;
    step(12);
    bus.req_v = '0;
    step(8);
    force_v = 1'b1; force_d = 16'hDEAD;
    step();
    force_v = 1'b0;
    step();
    check("ovf_set", 64'(ovf), 1);
    step(3);
    check("ovf_sticky", 64'(ovf), 1);
    check("full_out_v", 64'(bus.out_v), 1);
    bus.out_rdy = 1'b1;
    step(10);
    check("ovf_sticky_drain", 64'(ovf), 1);
    check("ovf_queue_empty", 64'(q.size()), 0);

    // Reset with samples in flight
    bus.req_v = 4'hF;
    step(3);
    bus.req_v = '0; rst_n = 1'b0; chk_en = 1'b0;
    model_reset();
    step();
    check("midrst_out_v", 64'(bus.out_v), 0);
    rst_n = 1'b1; chk_en = 1'b1;
    seen = 1'b0;
    repeat (12) begin @(negedge clk); if (bus.out_v) seen = 1'b1; end
    check("no_out_after_rst", 64'(seen), 0);
    check("ovf_cleared", 64'(ovf), 0);
    step();
    // ch2 gain was 0x8000 before reset; a restored table gives unity gain
    bus.req_data[2*DW +: DW] = 16'h0100; bus.req_v = 4'b0100;
    step();
    bus.req_v = '0;
    step(10);

    // Randomized traffic
    repeat (300) begin
      bus.req_v    = NUM_CH'($urandom_range(0, 15));
      bus.req_data = {$urandom, $urandom};
      bus.out_rdy  = ($urandom_range(0, 3) != 0);
      cfg_we       = ($urandom_range(0, 7) == 0);
      cfg_ch       = CHW'($urandom_range(0, NUM_CH - 1));
      cfg_gain     = GW'($urandom);
      step();
    end
    bus.req_v = '0; cfg_we = 1'b0; bus.out_rdy = 1'b1;
    t = 0;
    while (q.size() != 0 && t < 50) begin step(); t++; end
    check("drain_empty", 64'(q.size()), 0);
    step(5);
    check("final_ovf", 64'(ovf), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
